// File: rtl/sha256_main_block.sv
// sha256_main_block
// Datapath core of the SHA-256 engine. It holds the eight working variables
// A..H in a small addressed register file and performs one compression round
// per command. The host loads IVs word by word, issues rounds with a schedule
// word and round index, and reads results back one word per cycle. Message
// schedule generation and the final digest addition are done outside.
//
// Ports
//   clk           in   1   system clock, rising-edge
//   rst           in   1   asynchronous active-high reset
//   in_var        in  32   data word written to the register file
//   in_w          in  32   message schedule word W[t] for a round command
//   k_num         in   6   round index t, selects K[t] from the constant ROM
//   mem_in_addr   in   4   write/command address (1..8 = A..H, 15 = ROUND)
//   mem_out_addr  in   4   read address (1..8 = A..H, others read 0)
//   en_mem_out    in   1   out_var update enable
//   out_var       out 32   registered read data
//
// Command protocol: there is no valid/ready handshake. Every input is
// sampled on each rising edge and the command on mem_in_addr is accepted
// unconditionally on that edge. The block is never busy; a round, a write and
// a read may all be presented back to back, one per cycle. A read presented
// with en_mem_out=1 is visible on out_var after the same edge and always
// returns the value from before that edge.

module sha256_main_block (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_var,
  input  logic [31:0] in_w,
  input  logic [5:0]  k_num,
  input  logic [3:0]  mem_in_addr,
  input  logic [3:0]  mem_out_addr,
  input  logic        en_mem_out,
  output logic [31:0] out_var
);

  localparam logic [3:0] ADDR_NULL  = 4'd0;
  localparam logic [3:0] ADDR_A     = 4'd1;
  localparam logic [3:0] ADDR_B     = 4'd2;
  localparam logic [3:0] ADDR_C     = 4'd3;
  localparam logic [3:0] ADDR_D     = 4'd4;
  localparam logic [3:0] ADDR_E     = 4'd5;
  localparam logic [3:0] ADDR_F     = 4'd6;
  localparam logic [3:0] ADDR_G     = 4'd7;
  localparam logic [3:0] ADDR_H     = 4'd8;
  localparam logic [3:0] ADDR_ROUND = 4'd15;

  // Working variables
  logic [31:0] a, b, c, d, e, f, g, h;

  // Round datapath
  logic [31:0] k_val;
  logic [31:0] s1, ch, t1;
  logic [31:0] s0, maj, t2;
  logic [31:0] rd_data;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  // FIPS 180-4 round constants
  always_comb begin
    k_val = 32'h0;
    case (k_num)
      6'd0:  k_val = 32'h428a2f98;
      6'd1:  k_val = 32'h71374491;
      6'd2:  k_val = 32'hb5c0fbcf;
      6'd3:  k_val = 32'he9b5dba5;
      6'd4:  k_val = 32'h3956c25b;
      6'd5:  k_val = 32'h59f111f1;
      6'd6:  k_val = 32'h923f82a4;
      6'd7:  k_val = 32'hab1c5ed5;
      6'd8:  k_val = 32'hd807aa98;
      6'd9:  k_val = 32'h12835b01;
      6'd10: k_val = 32'h243185be;
      6'd11: k_val = 32'h550c7dc3;
      6'd12: k_val = 32'h72be5d74;
      6'd13: k_val = 32'h80deb1fe;
      6'd14: k_val = 32'h9bdc06a7;
      6'd15: k_val = 32'hc19bf174;
      6'd16: k_val = 32'he49b69c1;
      6'd17: k_val = 32'hefbe4786;
      6'd18: k_val = 32'h0fc19dc6;
      6'd19: k_val = 32'h240ca1cc;
      6'd20: k_val = 32'h2de92c6f;
      6'd21: k_val = 32'h4a7484aa;
      6'd22: k_val = 32'h5cb0a9dc;
      6'd23: k_val = 32'h76f988da;
      6'd24: k_val = 32'h983e5152;
      6'd25: k_val = 32'ha831c66d;
      6'd26: k_val = 32'hb00327c8;
      6'd27: k_val = 32'hbf597fc7;
      6'd28: k_val = 32'hc6e00bf3;
      6'd29: k_val = 32'hd5a79147;
      6'd30: k_val = 32'h06ca6351;
      6'd31: k_val = 32'h14292967;
      6'd32: k_val = 32'h27b70a85;
      6'd33: k_val = 32'h2e1b2138;
      6'd34: k_val = 32'h4d2c6dfc;
      6'd35: k_val = 32'h53380d13;
      6'd36: k_val = 32'h650a7354;
      6'd37: k_val = 32'h766a0abb;
      6'd38: k_val = 32'h81c2c92e;
      6'd39: k_val = 32'h92722c85;
      6'd40: k_val = 32'ha2bfe8a1;
      6'd41: k_val = 32'ha81a664b;
      6'd42: k_val = 32'hc24b8b70;
      6'd43: k_val = 32'hc76c51a3;
      6'd44: k_val = 32'hd192e819;
      6'd45: k_val = 32'hd6990624;
      6'd46: k_val = 32'hf40e3585;
      6'd47: k_val = 32'h106aa070;
      6'd48: k_val = 32'h19a4c116;
      6'd49: k_val = 32'h1e376c08;
      6'd50: k_val = 32'h2748774c;
      6'd51: k_val = 32'h34b0bcb5;
      6'd52: k_val = 32'h391c0cb3;
      6'd53: k_val = 32'h4ed8aa4a;
      6'd54: k_val = 32'h5b9cca4f;
      6'd55: k_val = 32'h682e6ff3;
      6'd56: k_val = 32'h748f82ee;
      6'd57: k_val = 32'h78a5636f;
      6'd58: k_val = 32'h84c87814;
      6'd59: k_val = 32'h8cc70208;
      6'd60: k_val = 32'h90befffa;
      6'd61: k_val = 32'ha4506ceb;
      6'd62: k_val = 32'hbef9a3f7;
      6'd63: k_val = 32'hc67178f2;
      default: k_val = 32'h0;
    endcase
  end

  // One full compression round from the current (pre-edge) variables.
  // All sums wrap mod 2^32 by truncation to 32 bits.
  always_comb begin
    s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    ch  = (e & f) ^ (~e & g);
    t1  = h + s1 + ch + k_val + in_w;
    s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t2  = s0 + maj;
  end

  // Read mux: null, reserved and command addresses all read as zero
  always_comb begin
    rd_data = 32'h0;
    case (mem_out_addr)
      ADDR_A:  rd_data = a;
      ADDR_B:  rd_data = b;
      ADDR_C:  rd_data = c;
      ADDR_D:  rd_data = d;
      ADDR_E:  rd_data = e;
      ADDR_F:  rd_data = f;
      ADDR_G:  rd_data = g;
      ADDR_H:  rd_data = h;
      default: rd_data = 32'h0;
    endcase
  end

  // Read port. rd_data is taken from the pre-edge registers, so a read in
  // the same cycle as a write or round returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_var <= 32'h0;
    end else if (en_mem_out) begin
      out_var <= rd_data;
    end
  end

  // Register file: host writes and round commands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= 32'h0;
      b <= 32'h0;
      c <= 32'h0;
      d <= 32'h0;
      e <= 32'h0;
      f <= 32'h0;
      g <= 32'h0;
      h <= 32'h0;
    end else begin
      case (mem_in_addr)
        ADDR_A: a <= in_var;
        ADDR_B: b <= in_var;
        ADDR_C: c <= in_var;
        ADDR_D: d <= in_var;
        ADDR_E: e <= in_var;
        ADDR_F: f <= in_var;
        ADDR_G: g <= in_var;
        ADDR_H: h <= in_var;
        ADDR_ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
        end
        default: ;  // null and reserved addresses: no change
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_main_block.sv
// Directed testbench for sha256_main_block. Expected values are hand-derived
// constants (SHA-256 IVs, the FIPS 180-4 "abc" round trace and K constants).
module tb_sha256_main_block;

  logic        clk;
  logic        rst;
  logic [31:0] in_var;
  logic [31:0] in_w;
  logic [5:0]  k_num;
  logic [3:0]  mem_in_addr;
  logic [3:0]  mem_out_addr;
  logic        en_mem_out;
  logic [31:0] out_var;

  int vectors;
  int errors;

  logic [31:0] iv [8];
  logic [31:0] exp_r0 [8];
  logic [31:0] exp_r2 [8];
  logic [31:0] held;

  sha256_main_block dut (
    .clk          (clk),
    .rst          (rst),
    .in_var       (in_var),
    .in_w         (in_w),
    .k_num        (k_num),
    .mem_in_addr  (mem_in_addr),
    .mem_out_addr (mem_out_addr),
    .en_mem_out   (en_mem_out),
    .out_var      (out_var)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    vectors++;
    assert (out_var === expected) else begin
      errors++;
      $error("FAIL %s: out_var=%h expected=%h", tag, out_var, expected);
    end
  endtask

  task automatic idle();
    mem_in_addr = 4'd0;
    en_mem_out  = 1'b0;
    in_var      = 32'h0;
    in_w        = 32'h0;
    k_num       = 6'd0;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    en_mem_out  = 1'b0;
    mem_in_addr = addr;
    in_var      = data;
    tick();
    mem_in_addr = 4'd0;
  endtask

  task automatic round(input logic [5:0] t, input logic [31:0] w);
    en_mem_out  = 1'b0;
    mem_in_addr = 4'd15;
    k_num       = t;
    in_w        = w;
    tick();
    mem_in_addr = 4'd0;
  endtask

  task automatic read_check(input logic [3:0] addr, input string tag,
                            input logic [31:0] expected);
    en_mem_out   = 1'b1;
    mem_in_addr  = 4'd0;
    mem_out_addr = addr;
    tick();
    en_mem_out   = 1'b0;
    check(tag, expected);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    iv     = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    exp_r0 = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
               32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
    exp_r2 = '{32'hc8c347a7, 32'h5a6ad9ad, 32'h5d6aebcd, 32'h6a09e667,
               32'hf92939eb, 32'h78ce7989, 32'hfa2a4622, 32'h510e527f};

    // Reset
    rst = 1'b1;
    mem_out_addr = 4'd0;
    idle();
    tick();
    tick();
    check("reset_out", 32'h0);
    #2 rst = 1'b0;
    tick();
    check("post_reset_out", 32'h0);
    for (int i = 0; i < 8; i++)
      read_check(4'(i + 1), $sformatf("reset_reg%0d", i + 1), 32'h0);

    // Load IV and read A, B
    for (int i = 0; i < 8; i++)
      write_reg(4'(i + 1), iv[i]);
    read_check(4'd1, "iv_a", 32'h6a09e667);
    read_check(4'd2, "iv_b", 32'hbb67ae85);

    // Hold: enable low, address moves, out_var must not change
    en_mem_out   = 1'b0;
    mem_out_addr = 4'd5;
    tick();
    mem_out_addr = 4'd3;
    tick();
    check("hold", 32'hbb67ae85);

    // Null/reserved reads and writes
    read_check(4'd0, "read_null", 32'h0);
    read_check(4'd9, "read_reserved", 32'h0);
    write_reg(4'd0, 32'hffffffff);
    write_reg(4'd9, 32'hffffffff);
    write_reg(4'd14, 32'h12345678);
    for (int i = 0; i < 8; i++)
      read_check(4'(i + 1), $sformatf("null_wr_reg%0d", i + 1), iv[i]);

    // Round 0 of "abc"
    round(6'd0, 32'h61626380);
    for (int i = 0; i < 8; i++)
      read_check(4'(i + 1), $sformatf("round0_reg%0d", i + 1), exp_r0[i]);

    // Round 1 (W=0), then round 2 issued together with a read of A:
    // the read must return A after round 1
    round(6'd1, 32'h0);
    read_check(4'd5, "round1_e", 32'h78ce7989);
    en_mem_out   = 1'b1;
    mem_out_addr = 4'd1;
    mem_in_addr  = 4'd15;
    k_num        = 6'd2;
    in_w         = 32'h0;
    tick();
    idle();
    check("round_rbw_a", 32'h5a6ad9ad);
    for (int i = 0; i < 8; i++)
      read_check(4'(i + 1), $sformatf("round2_reg%0d", i + 1), exp_r2[i]);

    // Write and read of the same address in one cycle
    en_mem_out   = 1'b1;
    mem_out_addr = 4'd1;
    mem_in_addr  = 4'd1;
    in_var       = 32'hdeadbeef;
    tick();
    idle();
    check("wr_rbw_old", 32'hc8c347a7);
    read_check(4'd1, "wr_rbw_new", 32'hdeadbeef);

    // Asynchronous reset between edges
    held = out_var;
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++)
      read_check(4'(i + 1), $sformatf("async_rst_reg%0d", i + 1), 32'h0);
    vectors++;
    assert (held === 32'hdeadbeef) else begin
      errors++;
      $error("FAIL pre_rst_hold: out_var=%h expected=%h", held, 32'hdeadbeef);
    end

    // K ROM boundaries from an all-zero state: T1 = K[t] + W, T2 = 0
    round(6'd63, 32'h0);
    read_check(4'd1, "k63_a", 32'hc67178f2);
    read_check(4'd5, "k63_e", 32'hc67178f2);
    read_check(4'd2, "k63_b", 32'h0);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    round(6'd32, 32'h5);
    read_check(4'd1, "k32_a", 32'h27b70a8a);
    read_check(4'd6, "k32_f", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
